// File: rtl/mul_pipe_stream_if.sv
// ----------------------------------------------------------------------------
// mul_pipe_stream_if
//   Stream bundle between mul_pipe_stream and its surroundings.
//   The operand side (in_*) and the result side (out_*) each use a
//   valid/ready handshake. flush and busy are carried here as well so that a
//   single connection wires up the whole block.
//
//   Parameters
//     DW  operand width
//     TW  tag width
//     RW  result width, always 2*DW (derived)
//
//   Signals (direction seen from the multiplier, i.e. the slave modport)
//     flush       in   synchronous pipeline clear
//     in_valid    in   operand beat valid
//     in_ready    out  multiplier can take a beat this cycle
//     in_a        in   multiplicand
//     in_b        in   multiplier
//     in_signed   in   1: operands are two's complement
//     in_tag      in   user tag, returned with the result
//     out_valid   out  result valid
//     out_ready   in   downstream takes the result
//     out_result  out  product
//     out_tag     out  tag belonging to out_result
//     busy        out  at least one operation in flight
//
//   Modports
//     master  operand producer / result consumer (drives in_*, out_ready, flush)
//     slave   the multiplier itself
// ----------------------------------------------------------------------------
interface mul_pipe_stream_if #(
    parameter int DW = 8,
    parameter int TW = 4
);
    localparam int RW = 2 * DW;

    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic          in_signed;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_result;
    logic [TW-1:0] out_tag;
    logic          busy;

    modport master (
        output flush,
        output in_valid,
        input  in_ready,
        output in_a,
        output in_b,
        output in_signed,
        output in_tag,
        input  out_valid,
        output out_ready,
        input  out_result,
        input  out_tag,
        input  busy
    );

    modport slave (
        input  flush,
        input  in_valid,
        output in_ready,
        input  in_a,
        input  in_b,
        input  in_signed,
        input  in_tag,
        output out_valid,
        input  out_ready,
        output out_result,
        output out_tag,
        output busy
    );
endinterface

// File: rtl/mul_pipe_stream.sv
// ----------------------------------------------------------------------------
// mul_pipe_stream
//   Streaming pipelined shift-add multiplier, DW x DW -> 2*DW.
//   Each of the STAGES = DW/BPS stages retires BPS bits of the multiplier.
//   Every stage has its own valid bit and a ready signal derived from the
//   stages behind it, so empty stages (bubbles) fill even while the output is
//   stalled, and a full pipe still accepts one beat per cycle when the result
//   side drains. A user tag travels alongside each operation untouched.
//
//   Parameters
//     DW      operand width                         (default 8)
//     BPS     multiplier bits consumed per stage    (default 2, DW % BPS == 0)
//     TW      tag width                             (default 4)
//     RW      result width = 2*DW                   (derived)
//     STAGES  pipeline depth = DW/BPS               (derived)
//
//   Ports
//     clk     clock
//     rst_n   asynchronous active-low reset
//     bus     mul_pipe_stream_if.slave: flush, in_* operand stream,
//             out_* result stream, busy
//
//   Compile-time option
//     MUL_SIGNED_EN  when defined, in_signed selects two's-complement
//                    operation per beat and a sign flag travels with each
//                    operation. When undefined, in_signed is ignored, every
//                    beat is unsigned and no sign-extension or subtract
//                    logic exists.
//
//   Latency is STAGES cycles from acceptance to out_valid when not stalled.
//   Results leave in acceptance order. All arithmetic is modulo 2^RW.
// ----------------------------------------------------------------------------
module mul_pipe_stream #(
    parameter  int DW     = 8,
    parameter  int BPS    = 2,
    parameter  int TW     = 4,
    localparam int RW     = 2 * DW,
    localparam int STAGES = DW / BPS
) (
    input logic                clk,
    input logic                rst_n,
    mul_pipe_stream_if.slave   bus
);

    if (DW % BPS != 0) begin : g_bad_bps
        $error("mul_pipe_stream: DW (%0d) must be a multiple of BPS (%0d)", DW, BPS);
    end

    // ------------------------------------------------------------------
    // Stage registers. Index k holds the state after stage k has folded
    // its BPS multiplier bits into the accumulator.
    // ------------------------------------------------------------------
    logic [STAGES-1:0] vld;
    logic [RW-1:0]     acc  [STAGES];
    logic [RW-1:0]     a_sh [STAGES];
    logic [DW-1:0]     b_sh [STAGES];
    logic [TW-1:0]     tag  [STAGES];
`ifdef MUL_SIGNED_EN
    logic [STAGES-1:0] sgn;
`endif

    // rdy[k]: stage k may load this cycle; rdy[STAGES] is the consumer.
    logic [STAGES:0]   rdy;
    logic              in_ready_int;
    logic              accept;
    logic [RW-1:0]     in_a_ext;

    // Values presented to each stage's input (stage 0 sees the operand port).
    logic [STAGES-1:0] src_vld;
    logic [RW-1:0]     src_acc [STAGES];
    logic [RW-1:0]     src_a   [STAGES];
    logic [DW-1:0]     src_b   [STAGES];
    logic [TW-1:0]     src_tag [STAGES];
    logic [RW-1:0]     nxt_acc [STAGES];
`ifdef MUL_SIGNED_EN
    logic [STAGES-1:0] src_sgn;
`endif

    // ------------------------------------------------------------------
    // Ready chain. A stage can load when it is empty or when the stage
    // after it can load, which reduces to: the consumer is ready, or some
    // stage at or beyond k is empty.
    // ------------------------------------------------------------------
    always_comb begin : p_rdy
        logic chain;
        chain       = bus.out_ready;
        rdy[STAGES] = chain;
        for (int k = STAGES - 1; k >= 0; k--) begin
            chain  = chain | ~vld[k];
            rdy[k] = chain;
        end
    end

    // A beat offered during flush is refused so it cannot survive the clear.
    assign in_ready_int = rdy[0] & ~bus.flush;
    assign accept       = bus.in_valid & in_ready_int;

`ifdef MUL_SIGNED_EN
    assign in_a_ext = {{DW{bus.in_signed & bus.in_a[DW-1]}}, bus.in_a};
`else
    assign in_a_ext = {{DW{1'b0}}, bus.in_a};

    // in_signed has no function in the unsigned-only build.
    logic unused_in_signed;
    assign unused_in_signed = bus.in_signed;
`endif

    // ------------------------------------------------------------------
    // Stage input selection.
    // ------------------------------------------------------------------
    // NOTE: every combinational output gets a value on every path (here by
    // assigning stage 0 first and all later stages in the loop); a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        src_vld[0] = accept;
        src_acc[0] = '0;
        src_a[0]   = in_a_ext;
        src_b[0]   = bus.in_b;
        src_tag[0] = bus.in_tag;
`ifdef MUL_SIGNED_EN
        src_sgn[0] = bus.in_signed;
`endif
        for (int k = 1; k < STAGES; k++) begin
            src_vld[k] = vld[k-1];
            src_acc[k] = acc[k-1];
            src_a[k]   = a_sh[k-1];
            src_b[k]   = b_sh[k-1];
            src_tag[k] = tag[k-1];
`ifdef MUL_SIGNED_EN
            src_sgn[k] = sgn[k-1];
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stage arithmetic: fold the low BPS bits of the shifted multiplier
    // into the accumulator. In signed mode the very last multiplier bit
    // (b[DW-1], seen by the last stage at position BPS-1) carries weight
    // -2^(DW-1), so its partial product is subtracted.
    // ------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            nxt_acc[k] = src_acc[k];
            for (int j = 0; j < BPS; j++) begin
`ifdef MUL_SIGNED_EN
                if (src_b[k][j] && src_sgn[k] && k == STAGES - 1 && j == BPS - 1)
                    nxt_acc[k] = nxt_acc[k] - (src_a[k] << j);
                else if (src_b[k][j])
                    nxt_acc[k] = nxt_acc[k] + (src_a[k] << j);
`else
                if (src_b[k][j])
                    nxt_acc[k] = nxt_acc[k] + (src_a[k] << j);
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Pipeline registers.
    // ------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every stage
    // samples its predecessor's pre-edge value; blocking assignments here
    // would let an operand ripple through several stages in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
`ifdef MUL_SIGNED_EN
            sgn <= '0;
`endif
            // NOTE: the data registers are reset too, not only the valid
            // bits, so out_result/out_tag read as zero after reset rather
            // than as leftovers of the dropped operations.
            for (int k = 0; k < STAGES; k++) begin
                acc[k]  <= '0;
                a_sh[k] <= '0;
                b_sh[k] <= '0;
                tag[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k]) begin
                    vld[k] <= src_vld[k];
                    // Data only moves with a real operation, so an
                    // emptied stage keeps its last contents.
                    if (src_vld[k]) begin
                        acc[k]  <= nxt_acc[k];
                        a_sh[k] <= src_a[k] << BPS;
                        b_sh[k] <= src_b[k] >> BPS;
                        tag[k]  <= src_tag[k];
`ifdef MUL_SIGNED_EN
                        sgn[k]  <= src_sgn[k];
`endif
                    end
                end
            end
            // Flush wins over any load: everything in flight is dropped.
            if (bus.flush)
                vld <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs straight from the last stage's registers.
    // ------------------------------------------------------------------
    assign bus.in_ready   = in_ready_int;
    assign bus.out_valid  = vld[STAGES-1];
    assign bus.out_result = acc[STAGES-1];
    assign bus.out_tag    = tag[STAGES-1];
    assign bus.busy       = |vld;

endmodule

// File: tb/tb_mul_pipe_stream.sv
// ----------------------------------------------------------------------------
// tb_mul_pipe_stream
//   Self-checking bench for mul_pipe_stream (DW=8, BPS=2, TW=4).
//   Expected products come from plain integer multiplication; a queue of
//   expected results holds acceptance order. Every cycle the bench records
//   acceptances and retirements, compares retired results against the queue,
//   and checks that a stalled output holds its value.
//   Signed cases run only when MUL_SIGNED_EN is defined.
// ----------------------------------------------------------------------------
module tb_mul_pipe_stream;

    localparam int DW     = 8;
    localparam int BPS    = 2;
    localparam int TW     = 4;
    localparam int RW     = 2 * DW;
    localparam int STAGES = DW / BPS;

    logic clk;
    logic rst_n;

    mul_pipe_stream_if #(.DW(DW), .TW(TW)) bus ();

    mul_pipe_stream #(.DW(DW), .BPS(BPS), .TW(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [RW-1:0] res;
        logic [TW-1:0] tag;
        int            cyc;
    } exp_t;

    exp_t          q[$];
    int            checks;
    int            errors;
    int            cycle;
    int            accepts;
    bit            check_lat;
    bit            stall_prev;
    logic [RW-1:0] prev_res;
    logic [TW-1:0] prev_tag;
    logic [RW-1:0] last_res;
    logic [TW-1:0] last_tag;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, expv);
        end
    endtask

    // Reference product: integer multiply, truncated to RW bits.
    function automatic logic [RW-1:0] ref_mul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic s);
        longint pa;
        longint pb;
        logic   eff_s;
        eff_s = s;
`ifndef MUL_SIGNED_EN
        eff_s = 1'b0;
`endif
        pa = longint'(a);
        pb = longint'(b);
        if (eff_s) begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
        end
        return RW'(pa * pb);
    endfunction

    // One clock cycle: called at a falling edge with inputs already driven.
    task automatic step();
        exp_t e;
        bit   acc_now;
        bit   ret_now;
        #2;
        acc_now = bus.in_valid && bus.in_ready;
        ret_now = bus.out_valid && bus.out_ready;
        if (stall_prev) begin
            check("hold_valid", bus.out_valid, 1);
            check("hold_result", bus.out_result, prev_res);
            check("hold_tag", bus.out_tag, prev_tag);
        end
        if (ret_now) begin
            check("result_expected", q.size() > 0, 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("result", bus.out_result, e.res);
                check("tag", bus.out_tag, e.tag);
                if (check_lat)
                    check("latency", cycle - e.cyc, STAGES);
            end
            last_res = bus.out_result;
            last_tag = bus.out_tag;
        end
        if (bus.flush)
            q.delete();
        if (acc_now) begin
            e.res = ref_mul(bus.in_a, bus.in_b, bus.in_signed);
            e.tag = bus.in_tag;
            e.cyc = cycle;
            q.push_back(e);
            accepts++;
        end
        stall_prev = bus.out_valid && !bus.out_ready && !bus.flush;
        prev_res   = bus.out_result;
        prev_tag   = bus.out_tag;
        @(posedge clk);
        @(negedge clk);
        cycle++;
    endtask

    task automatic drive(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s,
                         input logic [TW-1:0] t);
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_signed = s;
        bus.in_tag    = t;
    endtask

    task automatic drive_random();
        drive(DW'($urandom), DW'($urandom), 1'($urandom), TW'($urandom));
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while ((q.size() != 0 || bus.busy) && n < 64) begin
            step();
            n++;
        end
        check({name, "_drained"}, q.size(), 0);
        check({name, "_idle"}, bus.busy, 0);
    endtask

    task automatic run_one(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s,
                           input logic [TW-1:0] t, input logic [RW-1:0] expv, input string name);
        int a0;
        a0 = accepts;
        bus.out_ready = 1'b1;
        drive(a, b, s, t);
        step();
        check({name, "_accepted"}, accepts - a0, 1);
        bus.in_valid = 1'b0;
        drain(name);
        check({name, "_product"}, last_res, expv);
    endtask

    task automatic pulse_reset(input string name);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check({name, "_busy"}, bus.busy, 0);
        check({name, "_out_valid"}, bus.out_valid, 0);
        check({name, "_out_result"}, bus.out_result, 0);
        check({name, "_out_tag"}, bus.out_tag, 0);
        q.delete();
        stall_prev = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        check({name, "_in_ready"}, bus.in_ready, 1);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          a0;
        logic [5:0]  gap_pat;

        checks        = 0;
        errors        = 0;
        cycle         = 0;
        accepts       = 0;
        check_lat     = 1'b0;
        stall_prev    = 1'b0;
        last_res      = '0;
        last_tag      = '0;
        prev_res      = '0;
        prev_tag      = '0;
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_signed = 1'b0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;

        // Reset state.
        @(negedge clk);
        pulse_reset("reset");

        // Single unsigned beat with exact latency.
        check_lat = 1'b1;
        run_one(8'd13, 8'd11, 1'b0, 4'd5, 16'h008F, "t1");
        check("t1_tag", last_tag, 5);

        // Unsigned boundary operands.
        run_one(8'hF6, 8'h07, 1'b0, 4'd1, 16'h06BA, "t2_u_f6x07");
        run_one(8'hFF, 8'hFF, 1'b0, 4'd2, 16'hFE01, "t2_u_ffxff");
        run_one(8'h00, 8'hFF, 1'b0, 4'd3, 16'h0000, "t2_u_zero");
`ifdef MUL_SIGNED_EN
        run_one(8'hF6, 8'h07, 1'b1, 4'd4, 16'hFFBA, "t2_s_f6x07");
        run_one(8'h80, 8'h80, 1'b1, 4'd6, 16'h4000, "t2_s_80x80");
        run_one(8'hFF, 8'hFF, 1'b1, 4'd7, 16'h0001, "t2_s_ffxff");
        run_one(8'h7F, 8'h80, 1'b1, 4'd8, 16'hC080, "t2_s_7fx80");
`endif

        // Eight back-to-back beats; latency check forces consecutive results.
        a0 = accepts;
        for (int i = 0; i < 8; i++) begin
            drive(DW'(i), DW'(i + 1), 1'b0, TW'(i));
            #1;
            check("t3_in_ready", bus.in_ready, 1);
            step();
        end
        drain("t3");
        check("t3_accepts", accepts - a0, 8);
        check_lat = 1'b0;

        // Continuous stream against a six-cycle output stall.
        a0 = accepts;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_random();
            step();
        end
        #1;
        check("t4_accepts", accepts - a0, STAGES);
        check("t4_in_ready", bus.in_ready, 0);
        check("t4_out_valid", bus.out_valid, 1);
        drain("t4");

        // Gap between beats under stall: the bubble must collapse.
        a0 = accepts;
        bus.out_ready = 1'b0;
        gap_pat = 6'b001001;
        for (int i = 0; i < 6; i++) begin
            if (gap_pat[i])
                drive_random();
            else
                bus.in_valid = 1'b0;
            #1;
            check("t5_in_ready", bus.in_ready, 1);
            step();
        end
        check("t5_stage_valids", dut.vld, 4'b1100);
        for (int i = 0; i < 4; i++) begin
            drive_random();
            step();
        end
        #1;
        check("t5_accepts", accepts - a0, STAGES);
        check("t5_full_in_ready", bus.in_ready, 0);
        drain("t5");

        // Flush with three operations in flight.
        a0 = accepts;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_random();
            step();
        end
        drive_random();
        bus.flush = 1'b1;
        #1;
        check("t6_flush_in_ready", bus.in_ready, 0);
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("t6_flush_busy", bus.busy, 0);
        check("t6_flush_out_valid", bus.out_valid, 0);
        check("t6_flush_accepts", accepts - a0, 3);
        run_one(8'h12, 8'h34, 1'b0, 4'd9, 16'h03A8, "t6_after_flush");

        // Same, with a reset pulse instead of flush.
        for (int i = 0; i < 3; i++) begin
            drive_random();
            step();
        end
        pulse_reset("t6_rst");
        run_one(8'h12, 8'h34, 1'b0, 4'd10, 16'h03A8, "t6_after_rst");

        // Random traffic with random backpressure and occasional flushes.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0)
                drive_random();
            else
                bus.in_valid = 1'b0;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 49) == 0);
            step();
        end
        bus.flush = 1'b0;
        drain("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
